// File: rtl/cache_line_mem.sv
// Memory-side line responder for the data cache refill/eviction port.
// Serves one whole-line load or write-back at a time after a fixed latency.
module cache_line_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 128,
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_enable,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic                  write_back_enable,
  input  logic [ADDR_WIDTH-1:0] write_back_addr,
  input  logic [LINE_WIDTH-1:0] write_back_data,
  output logic [LINE_WIDTH-1:0] ldata,
  output logic                  load_finished,
  output logic                  write_back_finished,
  output logic                  busy
);

  localparam int IW = $clog2(DEPTH_LINES);
  localparam logic [3:0] LAST = 4'(LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    WB_WAIT,
    WB_DONE,
    LD_WAIT,
    LD_DONE
  } state_t;

  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [IW-1:0] idx;
  logic [LINE_WIDTH-1:0] wdata;
  logic [LINE_WIDTH-1:0] mem [DEPTH_LINES];
  logic acc_wb, acc_ld;
  logic wb_fire, ld_fire;

  // Upper and byte-offset address bits are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^{load_addr[ADDR_WIDTH-1:IW+4], load_addr[3:0],
                         write_back_addr[ADDR_WIDTH-1:IW+4],
                         write_back_addr[3:0]};

  // Next-state logic; write-back wins so the victim leaves before the refill.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    acc_wb  = 1'b0;
    acc_ld  = 1'b0;
    wb_fire = 1'b0;
    ld_fire = 1'b0;
    unique case (state)
      IDLE: begin
        if (write_back_enable) begin
          acc_wb  = 1'b1;
          cnt_n   = '0;
          state_n = WB_WAIT;
        end else if (load_enable) begin
          acc_ld  = 1'b1;
          cnt_n   = '0;
          state_n = LD_WAIT;
        end
      end
      WB_WAIT: begin
        cnt_n = cnt + 4'd1;
        if (cnt == LAST) begin
          wb_fire = 1'b1;
          state_n = WB_DONE;
        end
      end
      LD_WAIT: begin
        cnt_n = cnt + 4'd1;
        if (cnt == LAST) begin
          ld_fire = 1'b1;
          state_n = LD_DONE;
        end
      end
      WB_DONE: if (!write_back_enable) state_n = IDLE;
      LD_DONE: if (!load_enable) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, counter and request latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      wdata <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (acc_wb) begin
        idx   <= write_back_addr[IW+3:4];
        wdata <= write_back_data;
      end else if (acc_ld) begin
        idx <= load_addr[IW+3:4];
      end
    end
  end

  // Refill data register; holds until the next load completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ldata <= '0;
    else if (ld_fire) ldata <= mem[idx];
  end

  // Line storage, intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (wb_fire) mem[idx] <= wdata;
  end

  assign busy                = (state != IDLE);
  assign load_finished       = (state == LD_DONE);
  assign write_back_finished = (state == WB_DONE);

endmodule
